// File: rtl/prio_pkg.sv
// Shared encodings for the prio_enc_rr request arbiter.
package prio_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of vec scanning downward from a start index with wrap.
module prio_pick #(
    parameter  int WIDTH = 16,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDXW-1:0]  start,
    input  logic             rr,
    output logic             found,
    output logic [IDXW-1:0]  idx
);

    int              w_start;
    int              w_cand;
    logic [IDXW-1:0] w_cand_idx;

    // Fixed priority is a downward scan from the top index; iterating from the
    // farthest offset to the nearest leaves the closest hit in idx.
    always_comb begin
        found      = |vec;
        idx        = '0;
        w_start    = rr ? int'(start) : WIDTH - 1;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = WIDTH - 1; off >= 0; off--) begin
            w_cand = w_start - off;
            if (w_cand < 0) begin
                w_cand = w_cand + WIDTH;
            end
            w_cand_idx = IDXW'(w_cand);
            if (vec[w_cand_idx]) begin
                idx = w_cand_idx;
            end
        end
    end

endmodule

// File: rtl/prio_enc_rr.sv
// Sticky-request priority encoder with fixed or round-robin selection and a one-entry valid/ready output.
module prio_enc_rr
    import prio_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic             idle,
    output logic [IDXW:0]    pend_cnt
);

    logic [WIDTH-1:0] r_pend;
    logic             r_out_valid;
    logic [IDXW-1:0]  r_out_idx;
    logic [IDXW-1:0]  r_ptr;

    logic [WIDTH-1:0] w_eff;
    logic             w_rr;
    logic             w_found;
    logic [IDXW-1:0]  w_sel;
    logic             w_accept;
    logic             w_load;

    function automatic logic [IDXW:0] f_popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDXW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    assign w_eff    = r_pend | req;
    assign w_rr     = (mode == MODE_RR);
    assign w_accept = r_out_valid & out_ready;
    assign w_load   = (~r_out_valid | out_ready) & w_found;

    prio_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .vec   (w_eff),
        .start (r_ptr),
        .rr    (w_rr),
        .found (w_found),
        .idx   (w_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_ptr       <= IDXW'(WIDTH - 1);
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_sel;
            r_pend      <= w_eff & ~(WIDTH'(1) << w_sel);
            // Pointer tracks the last grant in both modes so a switch to RR
            // continues below whatever was granted most recently.
            r_ptr       <= (w_sel == '0) ? IDXW'(WIDTH - 1) : w_sel - IDXW'(1);
        end else begin
            r_pend <= w_eff;
            if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign idle      = ~r_out_valid & ~|r_pend;
    assign pend_cnt  = f_popcount(r_pend);

endmodule

// File: doc/prio_enc_rr.md
PRIO_ENC_RR -- requirements
Module: prio_enc_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of request lines (legal range 2..64).
REQ-002 SHALL have localparam IDXW, equal to $clog2(WIDTH), width of index outputs.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, WIDTH, request lines; bit k high requests index k.
REQ-006 SHALL have port mode, input, 1: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 SHALL have port out_ready, input, 1, consumer accepts out_idx when high with out_valid.
REQ-008 SHALL have port out_valid, output, 1, out_idx holds a granted index.
REQ-009 SHALL have port out_idx, output, IDXW, granted index.
REQ-010 SHALL have port idle, output, 1, high when nothing is pending and out_valid is low.
REQ-011 SHALL have port pend_cnt, output, IDXW+1, number of set bits in the pending register.

Function
REQ-012 SHALL keep a WIDTH-bit pending register (pend); requests are sticky until granted.
REQ-013 SHALL form eff = pend | req each cycle; selection operates on eff.
REQ-014 SHALL load the output register when out_valid is low or (out_valid and out_ready), and eff is non-zero.
REQ-015 SHALL, on load, set out_valid=1, out_idx=selected index, and pend <= eff with the selected bit cleared.
REQ-016 SHALL otherwise update pend <= eff and leave out_valid/out_idx unchanged.
REQ-017 SHALL clear out_valid on accept (out_valid and out_ready) when eff is zero.
REQ-018 SHALL hold out_idx stable while out_valid=1 and out_ready=0, regardless of req or mode changes.
REQ-019 SHALL give one-cycle latency: req high in cycle n with the output free gives out_valid high after edge n+1.
REQ-020 SHALL, in mode 0, select the highest set index of eff.
REQ-021 SHALL, in mode 1, select the first set bit of eff scanning downward from ptr, wrapping from index 0 to WIDTH-1.
REQ-022 SHALL update ptr on every load (both modes) to (selected-1) mod WIDTH; selected=0 gives ptr=WIDTH-1.
REQ-023 SHALL apply a mode change to the next load only.
REQ-024 SHALL treat req[k] asserted while k is held in out_idx as a new request: it sets pend[k] and is regranted later.
REQ-025 SHALL regrant index k the next cycle, with out_valid staying high, when k is accepted while req[k]=1 and it wins selection.
REQ-026 SHALL compute idle = ~out_valid & ~|pend, and pend_cnt = popcount(pend); both are registered-state derived, with no req path.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set pend=0, out_valid=0, out_idx=0 and ptr=WIDTH-1; idle reads 1 and pend_cnt reads 0 after that edge.
REQ-028 SHALL discard all pending and held grants on reset mid-operation; req in the reset cycle is ignored.

Structure
REQ-029 SHALL place the mode encoding constants (MODE_FIXED=0, MODE_RR=1) in shared package prio_pkg.
REQ-030 SHALL use one combinational sub-module prio_pick (inputs vec, start, rr; outputs found, idx), instantiated once.
REQ-031 SHALL keep all registers in prio_enc_rr; prio_pick holds no state.

Verification (WIDTH=16)
REQ-032 SHALL test mode 0 with req=16'h8001 for one cycle and out_ready=1: out_idx 15, then 0 on consecutive cycles, then out_valid=0 and idle=1.
REQ-033 SHALL test backpressure in mode 0: req=16'h0010 then 16'h0100 with out_ready=0: out_idx=4 held and pend_cnt=1; raising out_ready gives 4 accepted, then 8.
REQ-034 SHALL test mode 1 with req=16'hFFFF held and out_ready=1 after reset: out_idx sequence 15,14,...,0,15, one per cycle.
REQ-035 SHALL test a simultaneous event: idx 3 held, pend=0, out_ready=1 and req=16'h0008 in the same cycle: out_valid stays 1 with out_idx=3 on the next cycle.
REQ-036 SHALL test reset mid-operation: pend=16'h00FF with out_valid=1, rst high one cycle: pend_cnt=0, out_valid=0, idle=1; next RR grant starts from index 15.
